// File: rtl/pipe_pkg.sv
// Shared types for the execute->memory pipeline register: control bundle,
// result/size encodings and the skid-buffer state encoding.
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic [2:0] mem_size;
    } em_ctrl_t;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    // mem_size follows the load/store funct3 field
    localparam logic [2:0] MS_B  = 3'b000;
    localparam logic [2:0] MS_H  = 3'b001;
    localparam logic [2:0] MS_W  = 3'b010;
    localparam logic [2:0] MS_BU = 3'b100;
    localparam logic [2:0] MS_HU = 3'b101;

    localparam em_ctrl_t EM_CTRL_NOP = '0;

    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_ONE   = 2'd1,
        SB_FULL  = 2'd2
    } sb_state_t;

    // Side-effecting controls must never leave the stage without a valid beat
    function automatic em_ctrl_t gate_ctrl(input em_ctrl_t c, input logic vld);
        em_ctrl_t g;
        g           = c;
        g.reg_write = c.reg_write & vld;
        g.mem_write = c.mem_write & vld;
        return g;
    endfunction

endpackage

// File: rtl/pipe_reg_em_hs_if.sv
// Execute/memory beat bus: valid/ready handshake plus datapath and control payload.
// master drives the beat, slave returns ready.
interface pipe_reg_em_hs_if
    import pipe_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_W    = 5
);
    logic                     vld;
    logic                     rdy;
    logic [DATA_WIDTH-1:0]    alu_result;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [REG_ADDR_W-1:0]    rd;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    em_ctrl_t                 ctrl;

    modport master (output vld, alu_result, write_data, rd, pc_plus4, ctrl, input rdy);
    modport slave  (input vld, alu_result, write_data, rd, pc_plus4, ctrl, output rdy);
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer; main entry drives the output, skid absorbs one beat.
// Latency 1 cycle when empty; 1 beat/cycle sustained while out_rdy stays high.
// in_rdy is registered: drops only when both entries hold a beat.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter type T             = logic [7:0],
    parameter T    KEEP_ON_FLUSH = '0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic in_vld,
    output logic in_rdy,
    input  T     in_dat,
    output logic out_vld,
    input  logic out_rdy,
    output T     out_dat
);
    sb_state_t state_q;
    T          skid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SB_EMPTY;
            out_dat <= '0;
            skid_q  <= '0;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
        end else if (flush_i) begin
            // killed entries keep payload but lose whatever KEEP_ON_FLUSH masks off
            state_q <= SB_EMPTY;
            out_dat <= out_dat & KEEP_ON_FLUSH;
            skid_q  <= skid_q & KEEP_ON_FLUSH;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
        end else begin
            case (state_q)
                SB_EMPTY: begin
                    if (in_vld) begin
                        out_dat <= in_dat;
                        out_vld <= 1'b1;
                        state_q <= SB_ONE;
                    end
                end
                SB_ONE: begin
                    if (in_vld && out_rdy) begin
                        out_dat <= in_dat;
                    end else if (in_vld) begin
                        skid_q  <= in_dat;
                        in_rdy  <= 1'b0;
                        state_q <= SB_FULL;
                    end else if (out_rdy) begin
                        out_vld <= 1'b0;
                        state_q <= SB_EMPTY;
                    end
                end
                SB_FULL: begin
                    if (out_rdy) begin
                        out_dat <= skid_q;
                        in_rdy  <= 1'b1;
                        state_q <= SB_ONE;
                    end
                end
                default: begin
                    out_vld <= 1'b0;
                    in_rdy  <= 1'b1;
                    state_q <= SB_EMPTY;
                end
            endcase
        end
    end
endmodule

// File: rtl/pipe_reg_em_hs.sv
// Execute->memory pipeline register with valid/ready handshake, flush and optional skid.
// Latency 1 cycle when empty; full throughput while the memory side is ready.
// SKID=1: registered ready from a 2-entry buffer; SKID=0: ready = !valid | downstream ready.
module pipe_reg_em_hs
    import pipe_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_W    = 5,
    parameter bit SKID          = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    pipe_reg_em_hs_if.slave         e_if,
    pipe_reg_em_hs_if.master        m_if
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0]    alu_result;
        logic [DATA_WIDTH-1:0]    write_data;
        logic [REG_ADDR_W-1:0]    rd;
        logic [ADDRESS_WIDTH-1:0] pc_plus4;
        em_ctrl_t                 ctrl;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);
    localparam int CTRL_W = $bits(em_ctrl_t);
    // ctrl sits in the low bits: a flush clears it and leaves the datapath fields alone
    localparam beat_t KEEP_ON_FLUSH = beat_t'({{(BEAT_W-CTRL_W){1'b1}}, {CTRL_W{1'b0}}});

    beat_t in_beat;
    beat_t out_beat;
    logic  out_vld;

    always_comb begin
        in_beat.alu_result     = e_if.alu_result;
        in_beat.write_data     = e_if.write_data;
        in_beat.rd             = e_if.rd;
        in_beat.pc_plus4       = e_if.pc_plus4;
        in_beat.ctrl           = e_if.ctrl;
        in_beat.ctrl.reg_write = e_if.ctrl.reg_write & (e_if.rd != '0);
    end

    generate
        if (SKID) begin : g_skid
            pipe_skid_buf #(
                .T             (beat_t),
                .KEEP_ON_FLUSH (KEEP_ON_FLUSH)
            ) u_buf (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .flush_i (flush_i),
                .in_vld  (e_if.vld),
                .in_rdy  (e_if.rdy),
                .in_dat  (in_beat),
                .out_vld (out_vld),
                .out_rdy (m_if.rdy),
                .out_dat (out_beat)
            );
        end else begin : g_reg
            assign e_if.rdy = !out_vld | m_if.rdy;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    out_vld  <= 1'b0;
                    out_beat <= '0;
                end else if (flush_i) begin
                    out_vld  <= 1'b0;
                    out_beat <= out_beat & KEEP_ON_FLUSH;
                end else if (e_if.vld && e_if.rdy) begin
                    out_vld  <= 1'b1;
                    out_beat <= in_beat;
                end else if (m_if.rdy) begin
                    out_vld  <= 1'b0;
                end
            end
        end
    endgenerate

    assign m_if.vld        = out_vld;
    assign m_if.alu_result = out_beat.alu_result;
    assign m_if.write_data = out_beat.write_data;
    assign m_if.rd         = out_beat.rd;
    assign m_if.pc_plus4   = out_beat.pc_plus4;
    assign m_if.ctrl       = gate_ctrl(out_beat.ctrl, out_vld);
endmodule

// File: tb/tb_pipe_reg_em_hs.sv
// Directed bench for pipe_reg_em_hs: a SKID=1 instance for streaming, back-pressure,
// flush, x0 guard and reset, plus a SKID=0 instance for the combinational-ready variant.
module tb_pipe_reg_em_hs;
    import pipe_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    pipe_reg_em_hs_if e1();
    pipe_reg_em_hs_if m1();
    pipe_reg_em_hs_if e0();
    pipe_reg_em_hs_if m0();

    pipe_reg_em_hs #(.SKID(1'b1)) dut1 (
        .clk_i (clk), .rst_ni (rst_n), .flush_i (flush), .e_if (e1), .m_if (m1)
    );
    pipe_reg_em_hs #(.SKID(1'b0)) dut0 (
        .clk_i (clk), .rst_ni (rst_n), .flush_i (flush), .e_if (e0), .m_if (m0)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  src;
        logic        mw;
        logic [2:0]  sz;
        logic        exp_rw;
    } vec_t;
    vec_t vecs[8];

    logic [31:0] q1[$];
    logic [31:0] q0[$];

    // A handshake seen at the negedge completes at the following posedge
    always @(negedge clk) begin
        if (rst_n && m1.vld && m1.rdy) q1.push_back(m1.alu_result);
        if (rst_n && m0.vld && m0.rdy) q0.push_back(m0.alu_result);
    end

    task automatic drive1(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                          input logic [1:0] src, input logic mw, input logic [2:0] sz);
        e1.vld        = 1'b1;
        e1.alu_result = alu;
        e1.write_data = ~alu;
        e1.rd         = rd;
        e1.pc_plus4   = alu << 2;
        e1.ctrl       = '{reg_write: rw, result_src: src, mem_write: mw, mem_size: sz};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        e1.vld = 0; e1.alu_result = 0; e1.write_data = 0; e1.rd = 0; e1.pc_plus4 = 0; e1.ctrl = '0;
        e0.vld = 0; e0.alu_result = 0; e0.write_data = 0; e0.rd = 0; e0.pc_plus4 = 0; e0.ctrl = '0;
        m1.rdy = 0; m0.rdy = 0;

        vecs[0] = '{32'd1, 5'd5,  1'b1, RES_ALU, 1'b0, MS_W,  1'b1};
        vecs[1] = '{32'd2, 5'd0,  1'b1, RES_MEM, 1'b0, MS_B,  1'b0};
        vecs[2] = '{32'd3, 5'd1,  1'b1, RES_PC4, 1'b1, MS_H,  1'b1};
        vecs[3] = '{32'd4, 5'd0,  1'b0, RES_ALU, 1'b1, MS_BU, 1'b0};
        vecs[4] = '{32'd5, 5'd31, 1'b1, RES_MEM, 1'b0, MS_HU, 1'b1};
        vecs[5] = '{32'd6, 5'd7,  1'b0, RES_ALU, 1'b0, MS_W,  1'b0};
        vecs[6] = '{32'd7, 5'd0,  1'b1, RES_PC4, 1'b1, MS_B,  1'b0};
        vecs[7] = '{32'd8, 5'd2,  1'b1, RES_MEM, 1'b0, MS_H,  1'b1};

        // reset state
        #12;
        chk("rst_vld", m1.vld, 1'b0);
        chk("rst_alu", m1.alu_result, 32'h0);
        chk("rst_ctrl", m1.ctrl, 7'h0);
        chk("rst_s0_rdy", e0.rdy, 1'b1);
        #10 rst_n = 1'b1;
        step();
        chk("rst_rdy_after_release", e1.rdy, 1'b1);

        // streaming from the table, one beat per cycle
        m1.rdy = 1'b1;
        drive1(vecs[0].alu, vecs[0].rd, vecs[0].rw, vecs[0].src, vecs[0].mw, vecs[0].sz);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("str_vld[%0d]", i), m1.vld, 1'b1);
            chk($sformatf("str_alu[%0d]", i), m1.alu_result, vecs[i].alu);
            chk($sformatf("str_pc4[%0d]", i), m1.pc_plus4, vecs[i].alu << 2);
            chk($sformatf("str_rd[%0d]", i), m1.rd, vecs[i].rd);
            chk($sformatf("str_rw[%0d]", i), m1.ctrl.reg_write, vecs[i].exp_rw);
            chk($sformatf("str_mw[%0d]", i), m1.ctrl.mem_write, vecs[i].mw);
            chk($sformatf("str_src[%0d]", i), m1.ctrl.result_src, vecs[i].src);
            chk($sformatf("str_sz[%0d]", i), m1.ctrl.mem_size, vecs[i].sz);
            chk($sformatf("str_rdy[%0d]", i), e1.rdy, 1'b1);
            if (i < 7)
                drive1(vecs[i+1].alu, vecs[i+1].rd, vecs[i+1].rw, vecs[i+1].src,
                       vecs[i+1].mw, vecs[i+1].sz);
            else
                e1.vld = 1'b0;
        end
        step();
        chk("str_drained", m1.vld, 1'b0);

        // back-pressure: A, B fill both entries, C waits, then all drain in order
        q1.delete();
        m1.rdy = 1'b0;
        drive1(32'hA, 5'd3, 1'b1, RES_ALU, 1'b0, MS_W);
        step();
        chk("bp_a_out", m1.alu_result, 32'hA);
        chk("bp_rdy_after_a", e1.rdy, 1'b1);
        drive1(32'hB, 5'd3, 1'b1, RES_ALU, 1'b0, MS_W);
        step();
        chk("bp_rdy_after_b", e1.rdy, 1'b0);
        chk("bp_a_held", m1.alu_result, 32'hA);
        drive1(32'hC, 5'd3, 1'b1, RES_ALU, 1'b0, MS_W);
        step();
        chk("bp_a_stable", m1.alu_result, 32'hA);
        chk("bp_rdy_full", e1.rdy, 1'b0);
        m1.rdy = 1'b1;
        step();
        chk("bp_b_out", m1.alu_result, 32'hB);
        chk("bp_rdy_reopen", e1.rdy, 1'b1);
        step();
        chk("bp_c_out", m1.alu_result, 32'hC);
        e1.vld = 1'b0;
        step();
        chk("bp_empty", m1.vld, 1'b0);
        chk("bp_count", q1.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < q1.size()) chk($sformatf("bp_order[%0d]", i), q1[i], 32'hA + i);

        // flush from FULL with an incoming beat
        m1.rdy = 1'b0;
        drive1(32'h11, 5'd4, 1'b1, RES_MEM, 1'b1, MS_W);
        step();
        drive1(32'h22, 5'd4, 1'b1, RES_MEM, 1'b1, MS_W);
        step();
        chk("fl_full_rdy", e1.rdy, 1'b0);
        drive1(32'h33, 5'd4, 1'b1, RES_MEM, 1'b1, MS_W);
        flush = 1'b1;
        step();
        flush = 1'b0;
        e1.vld = 1'b0;
        chk("fl_vld", m1.vld, 1'b0);
        chk("fl_ctrl", m1.ctrl, 7'h0);
        chk("fl_payload_held", m1.alu_result, 32'h11);
        chk("fl_rdy", e1.rdy, 1'b1);
        q1.delete();
        m1.rdy = 1'b1;
        repeat (3) step();
        chk("fl_nothing_out", q1.size(), 0);
        chk("fl_still_empty", m1.vld, 1'b0);

        // flush from ONE while a beat is being accepted: the new beat is dropped too
        m1.rdy = 1'b0;
        drive1(32'h44, 5'd6, 1'b1, RES_ALU, 1'b1, MS_H);
        step();
        drive1(32'h55, 5'd6, 1'b1, RES_ALU, 1'b1, MS_H);
        flush = 1'b1;
        step();
        flush = 1'b0;
        e1.vld = 1'b0;
        chk("fl1_vld", m1.vld, 1'b0);
        chk("fl1_ctrl", m1.ctrl, 7'h0);
        chk("fl1_in_dropped", m1.alu_result, 32'h44);

        // reset asserted while a beat is held
        drive1(32'h66, 5'd3, 1'b1, RES_PC4, 1'b1, MS_B);
        step();
        e1.vld = 1'b0;
        chk("mrst_pre_vld", m1.vld, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", m1.vld, 1'b0);
        chk("mrst_ctrl", m1.ctrl, 7'h0);
        chk("mrst_alu", m1.alu_result, 32'h0);
        chk("mrst_wd", m1.write_data, 32'h0);
        chk("mrst_rd", m1.rd, 5'd0);
        chk("mrst_pc4", m1.pc_plus4, 32'h0);
        #2 rst_n = 1'b1;
        step();
        chk("mrst_rdy", e1.rdy, 1'b1);
        chk("mrst_empty", m1.vld, 1'b0);

        // SKID=0: downstream ready toggling, ready path checked every cycle
        begin
            int idx;
            logic take;
            idx = 0;
            q0.delete();
            e0.vld = 1'b1;
            e0.alu_result = 32'd1;
            e0.rd = 5'd9;
            e0.ctrl = '{reg_write: 1'b1, result_src: RES_ALU, mem_write: 1'b0, mem_size: MS_W};
            for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
                m0.rdy = (cyc % 2 == 0);
                #1;
                chk($sformatf("s0_rdy[%0d]", cyc), e0.rdy, !m0.vld | m0.rdy);
                take = e0.vld & e0.rdy;
                @(posedge clk);
                #1;
                if (take) begin
                    idx++;
                    if (idx < 6) e0.alu_result = idx + 1;
                    else e0.vld = 1'b0;
                end
            end
            m0.rdy = 1'b1;
            repeat (3) step();
            chk("s0_count", q0.size(), 6);
            for (int i = 0; i < 6; i++)
                if (i < q0.size()) chk($sformatf("s0_order[%0d]", i), q0[i], i + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
